// File: rtl/uart_frame_send.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_frame_send
//  Purpose  : Serialises the 16-bit waveform configuration word back to the
//             host as a 4-byte UART frame:
//                 0xA5, payload[7:0], payload[15:8], checksum
//             where checksum is the 8-bit sum of the three preceding bytes.
//             Each byte is 8N1 (start 0, 8 data bits LSB first, stop 1).
//             Bytes follow each other with no idle gap.
//  Ports    : sys_clk    - system clock
//             sys_rst_n  - asynchronous active-low reset
//             send_en    - one-cycle request; only accepted in IDLE
//             payload    - configuration word, latched on acceptance
//             uart_txd   - serial line, idle high
//             tx_busy    - high while a frame is in flight
//             tx_done    - one-cycle pulse when the frame completes
//  Revision : 1.0 - initial release
// ============================================================================
module uart_frame_send #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        send_en,
    input  logic [15:0] payload,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

    localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [7:0]       C_HEADER    = 8'hA5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [15:0]      payload_q,  payload_d;
    logic             txd_q,      txd_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic             bit_end;
    logic             accept;
    logic [7:0]       checksum;
    logic [7:0]       cur_byte;

    assign bit_end = (baud_cnt_q == C_BAUD_LAST);
    assign accept  = (state_q == S_IDLE) && send_en;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (send_en)                        state_d = S_START;
            S_START: if (bit_end)                        state_d = S_DATA;
            S_DATA:  if (bit_end && (bit_cnt_q == 3'd7)) state_d = S_STOP;
            S_STOP:  if (bit_end)
                         state_d = (byte_idx_q == 2'd3) ? S_IDLE : S_START;
            default:                                     state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and payload latch
    // ------------------------------------------------------------------
    always_comb begin
        // Baud counter restarts on every bit boundary and idles at zero, so
        // the START state entered from IDLE lasts exactly BPS_CNT cycles.
        if ((state_q == S_IDLE) || bit_end) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end

        bit_cnt_d = bit_cnt_q;
        if (state_d == S_IDLE) begin
            bit_cnt_d = 3'd0;
        end else if ((state_q == S_DATA) && bit_end) begin
            bit_cnt_d = bit_cnt_q + 3'd1;      // wraps 7 -> 0 into STOP
        end

        byte_idx_d = byte_idx_q;
        if (state_d == S_IDLE) begin
            byte_idx_d = 2'd0;
        end else if ((state_q == S_STOP) && (state_d == S_START)) begin
            byte_idx_d = byte_idx_q + 2'd1;
        end

        payload_d = accept ? payload : payload_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            payload_q  <= 16'd0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            payload_q  <= payload_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte selection; checksum is derived from the latched word so later
    // payload changes cannot disturb a frame in flight.
    // ------------------------------------------------------------------
    assign checksum = C_HEADER + payload_q[7:0] + payload_q[15:8];

    always_comb begin
        case (byte_idx_q)
            2'd0:    cur_byte = C_HEADER;
            2'd1:    cur_byte = payload_q[7:0];
            2'd2:    cur_byte = payload_q[15:8];
            default: cur_byte = checksum;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so the registered outputs
    // line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && (state_d == S_IDLE);
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = cur_byte[bit_cnt_d];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            txd_q  <= txd_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_send.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_frame_send
//  Purpose  : Self-checking bench for uart_frame_send. One instance at the
//             default baud parameters and one at CLK_FREQ=1000/UART_BPS=100.
//             Expected line waveforms come from a frame model built from the
//             byte/bit ordering rules; decoded bytes are also compared with
//             literal values for the directed cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_send;

    localparam int B_BIG = 50000000 / 115200;
    localparam int B_SML = 1000 / 100;

    logic        sys_clk     = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        send_en_big = 1'b0;
    logic        send_en_sml = 1'b0;
    logic [15:0] payload_big = 16'd0;
    logic [15:0] payload_sml = 16'd0;
    logic        txd_big, busy_big, done_big;
    logic        txd_sml, busy_sml, done_sml;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  rx_bytes [4];

    always #5 sys_clk = ~sys_clk;

    uart_frame_send u_dut_big (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .send_en   (send_en_big),
        .payload   (payload_big),
        .uart_txd  (txd_big),
        .tx_busy   (busy_big),
        .tx_done   (done_big)
    );

    uart_frame_send #(
        .CLK_FREQ (1000),
        .UART_BPS (100)
    ) u_dut_sml (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .send_en   (send_en_sml),
        .payload   (payload_sml),
        .uart_txd  (txd_sml),
        .tx_busy   (busy_sml),
        .tx_done   (done_sml)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        check({tag, " byte0"}, rx_bytes[0], e0);
        check({tag, " byte1"}, rx_bytes[1], e1);
        check({tag, " byte2"}, rx_bytes[2], e2);
        check({tag, " byte3"}, rx_bytes[3], e3);
    endtask

    // Reference frame: 40 line bits in transmission order.
    function automatic logic [39:0] frame_bits(input logic [15:0] pl);
        logic [7:0]  by [4];
        logic [39:0] f;
        by[0] = 8'hA5;
        by[1] = pl[7:0];
        by[2] = pl[15:8];
        by[3] = 8'((int'(by[0]) + int'(by[1]) + int'(by[2])) % 256);
        f = '0;
        for (int b = 0; b < 4; b++) begin
            f[b*10] = 1'b0;
            for (int i = 0; i < 8; i++) f[b*10+1+i] = by[b][i];
            f[b*10+9] = 1'b1;
        end
        return f;
    endfunction

    task automatic drive_send(input bit big, input logic en, input logic [15:0] pl);
        if (big) begin
            send_en_big = en;
            payload_big = pl;
        end else begin
            send_en_sml = en;
            payload_sml = pl;
        end
    endtask

    task automatic sample(input bit big, output logic t, output logic b, output logic d);
        t = big ? txd_big  : txd_sml;
        b = big ? busy_big : busy_sml;
        d = big ? done_big : done_sml;
    endtask

    // Pulse send_en for one cycle; returns just after the accepting edge.
    task automatic start_send(input bit big, input logic [15:0] pl);
        @(negedge sys_clk);
        drive_send(big, 1'b1, pl);
        @(posedge sys_clk);
        #1;
        drive_send(big, 1'b0, 16'($urandom));
    endtask

    // Called just after edge N. Checks every cycle of the frame, optionally
    // pulses send_en at cycle N+inj_at (expected to be ignored), and
    // optionally requests the next frame on the tx_done cycle.
    task automatic watch_frame(input bit big, input logic [15:0] pl, input int inj_at,
                               input logic [15:0] inj_pl, input bit chain,
                               input logic [15:0] chain_pl);
        int          bps;
        int          k;
        int          j;
        logic [39:0] exp_bits;
        logic        t, b, d;
        bps      = big ? B_BIG : B_SML;
        exp_bits = frame_bits(pl);
        for (int c = 1; c <= 40*bps; c++) begin
            @(negedge sys_clk);
            if (c == inj_at) drive_send(big, 1'b1, inj_pl);
            else if (c == inj_at + 1) drive_send(big, 1'b0, 16'($urandom));
            sample(big, t, b, d);
            k = (c - 1) / bps;
            check($sformatf("txd bit%0d", k), t, exp_bits[k]);
            check("busy in frame", b, 1);
            check("done in frame", d, 0);
            j = k % 10;
            if (((c - 1) % bps == bps / 2) && (j >= 1) && (j <= 8))
                rx_bytes[k/10][j-1] = t;
        end
        @(negedge sys_clk);
        drive_send(big, chain, chain ? chain_pl : 16'($urandom));
        sample(big, t, b, d);
        check("done pulse", d, 1);
        check("busy at done", b, 0);
        check("txd at done", t, 1);
        if (chain) begin
            @(posedge sys_clk);
            #1;
            drive_send(big, 1'b0, 16'($urandom));
        end else begin
            for (int c = 0; c < 3; c++) begin
                @(negedge sys_clk);
                sample(big, t, b, d);
                check("idle busy", b, 0);
                check("idle txd", t, 1);
                check("idle done", d, 0);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pl;
        logic [15:0] nxt;
        bit          ch;
        int          inj;

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst txd big",  txd_big,  1);
        check("rst busy big", busy_big, 0);
        check("rst done big", done_big, 0);
        check("rst txd sml",  txd_sml,  1);
        check("rst busy sml", busy_sml, 0);
        check("rst done sml", done_sml, 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Default baud: basic frame, with a rejected request at N+5000
        start_send(1'b1, 16'h1234);
        watch_frame(1'b1, 16'h1234, 5000, 16'hABCD, 1'b0, 16'h0);
        check_bytes("basic", 8'hA5, 8'h34, 8'h12, 8'hEB);

        // Checksum wrap
        start_send(1'b0, 16'hFFFF);
        watch_frame(1'b0, 16'hFFFF, 0, 16'h0, 1'b0, 16'h0);
        check_bytes("wrap", 8'hA5, 8'hFF, 8'hFF, 8'hA3);

        // Back-to-back on the tx_done cycle
        start_send(1'b0, 16'h1234);
        watch_frame(1'b0, 16'h1234, 0, 16'h0, 1'b1, 16'h0001);
        check_bytes("b2b first", 8'hA5, 8'h34, 8'h12, 8'hEB);
        watch_frame(1'b0, 16'h0001, 0, 16'h0, 1'b0, 16'h0);
        check_bytes("b2b second", 8'hA5, 8'h01, 8'h00, 8'hA6);

        // send_en held high for 50 cycles starts exactly one frame
        @(negedge sys_clk);
        drive_send(1'b0, 1'b1, 16'h5AC3);
        @(posedge sys_clk);
        #1;
        drive_send(1'b0, 1'b1, 16'($urandom));
        watch_frame(1'b0, 16'h5AC3, 50, 16'h9999, 1'b0, 16'h0);

        // Reset during the data bits of byte 1
        start_send(1'b0, 16'h5A5A);
        repeat (13*B_SML + 3) @(negedge sys_clk);
        check("pre-rst busy", busy_sml, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async rst txd",  txd_sml,  1);
        check("async rst busy", busy_sml, 0);
        check("async rst done", done_sml, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            check("in rst done", done_sml, 0);
            check("in rst txd",  txd_sml,  1);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        start_send(1'b0, 16'h00AA);
        watch_frame(1'b0, 16'h00AA, 0, 16'h0, 1'b0, 16'h0);
        check_bytes("after rst", 8'hA5, 8'hAA, 8'h00, 8'h4F);

        // Randomised frames with random ignored requests and chaining
        pl = 16'($urandom);
        start_send(1'b0, pl);
        for (int i = 0; i < 20; i++) begin
            nxt = 16'($urandom);
            ch  = (i < 19) && ($urandom_range(0, 1) == 1);
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40*B_SML)) : 0;
            watch_frame(1'b0, pl, inj, 16'($urandom), ch, nxt);
            pl = nxt;
            if (!ch && (i < 19)) begin
                repeat ($urandom_range(0, 4)) @(negedge sys_clk);
                start_send(1'b0, pl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
